// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the stage sequencer and the control signal generator.
// The master side drives the run/decode/memory status inputs; the slave side
// (the sequencer) drives stage, request and counter outputs.
interface stage_sequencer_if;
    logic        Run;
    logic        NOP_FLAG;
    logic        IFNR_FLAG;
    logic        Mem_Access;
    logic        Mem_Ready;
    logic [2:0]  Stage;
    logic        Mem_Request;
    logic        Stage_Done;
    logic        Fault;
    logic [31:0] Instruction_Count;
    logic [15:0] Stall_Count;

    modport master (
        output Run, NOP_FLAG, IFNR_FLAG, Mem_Access, Mem_Ready,
        input  Stage, Mem_Request, Stage_Done, Fault, Instruction_Count, Stall_Count
    );

    modport slave (
        input  Run, NOP_FLAG, IFNR_FLAG, Mem_Access, Mem_Ready,
        output Stage, Mem_Request, Stage_Done, Fault, Instruction_Count, Stall_Count
    );
endinterface

// File: rtl/stage_sequencer.sv
// Multicycle stage sequencer for the five-stage processor.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE  (0) | waiting for Run
// FETCH (1) | instruction fetch, request held until Mem_Ready or timeout
// DECODE(2) | one cycle; traps bad formats, retires NOPs early
// EXEC  (3) | one cycle
// MEM   (4) | one cycle, or a fetch-like request when Mem_Access is set
// WB    (5) | one cycle; retires the instruction
// FAULT (7) | sticky trap, only Reset leaves it
module stage_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input logic           Clock,
    input logic           Reset,
    stage_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_FAULT  = 3'd7
    } stage_t;

    localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

    stage_t      r_state;
    stage_t      w_next;
    logic [7:0]  r_wait;
    logic [31:0] r_icount;
    logic [15:0] r_stall;
    logic        w_stalled;
    logic        w_timeout;
    logic        w_retire;

    // A request cycle without Mem_Ready is a wait cycle; the last allowed one traps.
    assign w_stalled = bus.Mem_Request & ~bus.Mem_Ready;
    assign w_timeout = w_stalled && (r_wait == TO_LAST);
    assign w_retire  = (r_state == S_WB) ||
                       ((r_state == S_DECODE) && !bus.IFNR_FLAG && bus.NOP_FLAG);

    // State register.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state selection.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.Run) w_next = S_FETCH;
            S_FETCH: begin
                if (bus.Mem_Ready)   w_next = S_DECODE;
                else if (w_timeout)  w_next = S_FAULT;
            end
            S_DECODE: begin
                if (bus.IFNR_FLAG)      w_next = S_FAULT;
                else if (bus.NOP_FLAG)  w_next = bus.Run ? S_FETCH : S_IDLE;
                else                    w_next = S_EXEC;
            end
            S_EXEC:   w_next = S_MEM;
            S_MEM: begin
                if (!bus.Mem_Access || bus.Mem_Ready) w_next = S_WB;
                else if (w_timeout)                   w_next = S_FAULT;
            end
            S_WB:     w_next = bus.Run ? S_FETCH : S_IDLE;
            S_FAULT:  w_next = S_FAULT;
            default:  w_next = S_FAULT;
        endcase
    end

    // Request and stage-done decode from the registered state.
    always_comb begin
        bus.Mem_Request = 1'b0;
        bus.Stage_Done  = 1'b0;
        case (r_state)
            S_IDLE:   bus.Stage_Done = bus.Run & ~Reset;
            S_FETCH: begin
                bus.Mem_Request = 1'b1;
                bus.Stage_Done  = bus.Mem_Ready;
            end
            S_DECODE, S_EXEC, S_WB: bus.Stage_Done = 1'b1;
            S_MEM: begin
                bus.Mem_Request = bus.Mem_Access;
                bus.Stage_Done  = ~bus.Mem_Access | bus.Mem_Ready;
            end
            default: begin
                bus.Mem_Request = 1'b0;
                bus.Stage_Done  = 1'b0;
            end
        endcase
    end

    // Per-stage wait counter, restarted whenever a new stage is entered.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                  r_wait <= 8'd0;
        else if (w_next != r_state) r_wait <= 8'd0;
        else if (w_stalled)         r_wait <= r_wait + 8'd1;
    end

    // Retired-instruction counter, free-running modulo 2^32.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)         r_icount <= 32'd0;
        else if (w_retire) r_icount <= r_icount + 32'd1;
    end

    // Total stall counter, saturating.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                               r_stall <= 16'd0;
        else if (w_stalled && r_stall != 16'hFFFF) r_stall <= r_stall + 16'd1;
    end

    assign bus.Stage             = r_state;
    assign bus.Fault             = (r_state == S_FAULT);
    assign bus.Instruction_Count = r_icount;
    assign bus.Stall_Count       = r_stall;
endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with a behavioural reference model.
module tb_stage_sequencer;
    localparam int TO = 15;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    stage_sequencer_if sif();

    stage_sequencer #(.MEM_TIMEOUT(TO)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (sif)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: which stage follows a completed one, stall bookkeeping.
    int          m_stage = 0;
    int          m_waited = 0;
    logic [31:0] m_icount = 0;
    int          m_stall = 0;

    function automatic bit m_req();
        return (m_stage == 1) || (m_stage == 4 && sif.Mem_Access);
    endfunction

    function automatic bit m_done();
        case (m_stage)
            0:       return sif.Run && !Reset;
            1:       return sif.Mem_Ready;
            2, 3, 5: return 1'b1;
            4:       return !sif.Mem_Access || sif.Mem_Ready;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge Clock or posedge Reset) begin
        int nxt;
        if (Reset) begin
            m_stage = 0; m_waited = 0; m_icount = 0; m_stall = 0;
        end else begin
            nxt = m_stage;
            if (m_req() && !sif.Mem_Ready) begin
                m_waited++;
                if (m_stall < 65535) m_stall++;
                if (m_waited >= TO) nxt = 7;
            end else if (m_done()) begin
                case (m_stage)
                    0: nxt = 1;
                    1: nxt = 2;
                    2: begin
                        if (sif.IFNR_FLAG) nxt = 7;
                        else if (sif.NOP_FLAG) begin
                            m_icount++;
                            nxt = sif.Run ? 1 : 0;
                        end else nxt = 3;
                    end
                    3: nxt = 4;
                    4: nxt = 5;
                    5: begin
                        m_icount++;
                        nxt = sif.Run ? 1 : 0;
                    end
                    default: nxt = 7;
                endcase
            end
            if (nxt != m_stage) m_waited = 0;
            m_stage = nxt;
        end
    end

    // Every-cycle comparison against the model, sampled mid-cycle.
    always @(negedge Clock) begin
        if (Reset) begin
            chk("rst_stage", 32'(sif.Stage), 32'd0);
            chk("rst_req",   32'(sif.Mem_Request), 32'd0);
            chk("rst_done",  32'(sif.Stage_Done), 32'd0);
            chk("rst_cnt",   sif.Instruction_Count, 32'd0);
        end else begin
            chk("m_stage", 32'(sif.Stage), 32'(m_stage));
            chk("m_req",   32'(sif.Mem_Request), 32'(m_req()));
            chk("m_done",  32'(sif.Stage_Done), 32'(m_done()));
            chk("m_fault", 32'(sif.Fault), 32'(m_stage == 7));
            chk("m_icnt",  sif.Instruction_Count, m_icount);
            chk("m_stall", 32'(sif.Stall_Count), 32'(m_stall));
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        int seq_exp [6] = '{1, 2, 3, 4, 5, 1};
        logic dn [4];
        int   req_cycles;

        sif.Run = 1'b0; sif.NOP_FLAG = 1'b0; sif.IFNR_FLAG = 1'b0;
        sif.Mem_Access = 1'b0; sif.Mem_Ready = 1'b0;
        tick(); tick();
        sif.Run = 1'b1;
        #1;
        chk("reset_stage", 32'(sif.Stage), 32'd0);
        chk("reset_done_run_ignored", 32'(sif.Stage_Done), 32'd0);
        chk("reset_fault", 32'(sif.Fault), 32'd0);
        chk("reset_stall", 32'(sif.Stall_Count), 32'd0);
        tick();

        // Zero-wait instruction.
        sif.Mem_Ready = 1'b1;
        Reset = 1'b0;
        #1;
        chk("zw_idle", 32'(sif.Stage), 32'd0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("zw_seq", 32'(sif.Stage), 32'(seq_exp[i]));
        end
        chk("zw_icount", sif.Instruction_Count, 32'd1);
        chk("zw_stall", 32'(sif.Stall_Count), 32'd0);

        // Fetch with three wait states.
        for (int i = 0; i < 4; i++) begin
            sif.Mem_Ready = (i == 3);
            #1;
            dn[i] = sif.Stage_Done;
            chk("fw_in_fetch", 32'(sif.Stage), 32'd1);
            tick();
        end
        chk("fw_done0", 32'(dn[0]), 32'd0);
        chk("fw_done2", 32'(dn[2]), 32'd0);
        chk("fw_done3", 32'(dn[3]), 32'd1);
        chk("fw_decode", 32'(sif.Stage), 32'd2);
        chk("fw_stall", 32'(sif.Stall_Count), 32'd3);

        // NOP retire, then IFNR over NOP.
        sif.NOP_FLAG = 1'b1;
        tick();
        chk("nop_fetch", 32'(sif.Stage), 32'd1);
        chk("nop_icount", sif.Instruction_Count, 32'd2);
        tick();
        chk("nop2_decode", 32'(sif.Stage), 32'd2);
        sif.IFNR_FLAG = 1'b1;
        tick();
        chk("ifnr_stage", 32'(sif.Stage), 32'd7);
        chk("ifnr_fault", 32'(sif.Fault), 32'd1);
        chk("ifnr_icount", sif.Instruction_Count, 32'd2);
        sif.IFNR_FLAG = 1'b0; sif.NOP_FLAG = 1'b0;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;

        // Run dropped during Execute.
        tick(); tick(); tick();
        chk("rd_exec", 32'(sif.Stage), 32'd3);
        sif.Run = 1'b0;
        tick(); tick(); tick();
        chk("rd_idle", 32'(sif.Stage), 32'd0);
        chk("rd_icount", sif.Instruction_Count, 32'd1);
        tick();
        chk("rd_stay_idle", 32'(sif.Stage), 32'd0);

        // Memory-stage timeout.
        sif.Run = 1'b1;
        tick(); tick();
        sif.Mem_Access = 1'b1; sif.Mem_Ready = 1'b0; sif.Run = 1'b0;
        tick(); tick();
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            if (sif.Stage == 3'd7) break;
            if (sif.Mem_Request) req_cycles++;
            tick();
        end
        chk("to_req_cycles", 32'(req_cycles), 32'd15);
        chk("to_stage", 32'(sif.Stage), 32'd7);
        chk("to_fault", 32'(sif.Fault), 32'd1);
        chk("to_stall", 32'(sif.Stall_Count), 32'd15);
        sif.Run = 1'b1;
        for (int i = 0; i < 100; i++) begin
            sif.Mem_Ready = i[0];
            tick();
        end
        chk("to_held", 32'(sif.Stage), 32'd7);
        chk("to_held_req", 32'(sif.Mem_Request), 32'd0);

        // Reset in the middle of a fetch wait.
        Reset = 1'b1;
        tick();
        sif.Mem_Access = 1'b0; sif.Mem_Ready = 1'b0;
        Reset = 1'b0;
        tick(); tick();
        chk("rm_req_before", 32'(sif.Mem_Request), 32'd1);
        #2 Reset = 1'b1;
        #1;
        chk("rm_req_async", 32'(sif.Mem_Request), 32'd0);
        chk("rm_stage", 32'(sif.Stage), 32'd0);
        chk("rm_icount", sif.Instruction_Count, 32'd0);
        chk("rm_stall", 32'(sif.Stall_Count), 32'd0);
        chk("rm_done", 32'(sif.Stage_Done), 32'd0);
        tick();
        Reset = 1'b0;
        tick();
        chk("rm_resume", 32'(sif.Stage), 32'd1);

        // Mem_Ready arriving on the timeout cycle completes the stage.
        for (int i = 0; i < TO; i++) begin
            sif.Mem_Ready = (i == TO - 1);
            tick();
        end
        chk("rt_decode", 32'(sif.Stage), 32'd2);
        chk("rt_stall", 32'(sif.Stall_Count), 32'd14);
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multicycle stage sequencer for the five-stage processor: replaces the free-running stage counter with a state machine that walks Fetch, Decode, Execute, Memory and Write Back. It holds a stage while memory is busy, retires NOPs early and traps unrecognised instruction formats. It sits beside the stage-enable logic in the control signal generator, which consumes `Stage` and `Stage_Done` to qualify the register enables.

## Interface
- `MEM_TIMEOUT`, default 15: maximum cycles `Mem_Request` may stay high in one stage without `Mem_Ready`. Legal range 1..255.
- `Clock` input 1: single clock; all state updates on the rising edge.
- `Reset` input 1: asynchronous, active-high; clears all state.
- `Run` input 1: level; start or continue executing instructions.
- `NOP_FLAG` input 1: decoded instruction is a NOP; sampled in Decode.
- `IFNR_FLAG` input 1: instruction format not recognised; sampled in Decode.
- `Mem_Access` input 1: current instruction reads or writes data memory; sampled in Memory.
- `Mem_Ready` input 1: memory has completed the outstanding request.
- `Stage` output 3: 0 Idle, 1 Fetch, 2 Decode, 3 Execute, 4 Memory, 5 WriteBack, 7 Fault; 6 is unused.
- `Mem_Request` output 1: memory request. Held high in Fetch, and in Memory when `Mem_Access` is 1.
- `Stage_Done` output 1: combinational; high in the final cycle of the current stage.
- `Fault` output 1: sticky error indicator; equals (`Stage`==7).
- `Instruction_Count` output 32: retired instructions; wraps modulo 2^32.
- `Stall_Count` output 16: total memory wait cycles; saturates at 0xFFFF.

## Operation
- **Idle:** moves to Fetch when `Run`=1. `Stage_Done`=`Run`.
- **Fetch:** `Mem_Request`=1.
  - `Mem_Ready`=1 sets `Stage_Done` and moves to Decode.
  - A timeout (see below) moves to Fault.
- **Decode:** one cycle, `Stage_Done`=1.
  - `IFNR_FLAG`=1 moves to Fault. This has priority over `NOP_FLAG`.
  - `NOP_FLAG`=1 retires the NOP (`Instruction_Count`+1) and moves to Fetch if `Run`=1, else to Idle.
  - Otherwise moves to Execute.
- **Execute:** one cycle, `Stage_Done`=1, then Memory.
- **Memory:**
  - `Mem_Access`=0: one cycle, `Stage_Done`=1.
  - `Mem_Access`=1: behaves as Fetch (request, wait, timeout).
  - On completion moves to WriteBack.
- **WriteBack:** one cycle, `Stage_Done`=1, `Instruction_Count`+1. Moves to Fetch if `Run`=1, else to Idle.
- **Fault:** all requests are low and `Stage_Done`=0. Only `Reset` exits Fault.
- **Wait counter (8-bit, internal):**
  - Cleared on entry to any stage.
  - Increments on each cycle where `Mem_Request`=1 and `Mem_Ready`=0; `Stall_Count` increments (saturating) on the same cycles.
  - If the wait counter equals `MEM_TIMEOUT`-1 while `Mem_Ready`=0, the next state is Fault. `Mem_Request` is therefore high for at most `MEM_TIMEOUT` consecutive cycles.
- `Mem_Ready` is ignored whenever `Mem_Request`=0.
- `Run` is sampled only in Idle, at Decode NOP retire, and at WriteBack. Dropping `Run` mid-instruction lets that instruction complete.

## Timing
- Reset values: `Stage`=0, `Mem_Request`=0, `Stage_Done`=0 (since `Run` is ignored under `Reset`), `Fault`=0, `Instruction_Count`=0, `Stall_Count`=0, wait counter 0.
- `Stage`, `Fault` and both counters are registered. `Mem_Request` decodes from the registered state and `Mem_Access` only.
- Zero-wait memory: when `Mem_Ready` is high in the first request cycle, the stage lasts 1 cycle.
- Latency with zero-wait memory:
  - Full instruction: 5 cycles.
  - NOP: 2 cycles (Fetch, Decode).
  - First Fetch: one cycle after `Run` is seen in Idle.
- `Instruction_Count` updates on the clock edge that leaves WriteBack, or leaves Decode on a NOP.
- Asserting `Reset` mid-request drops `Mem_Request` asynchronously, with no wait for a clock edge.
- `Mem_Ready` and timeout in the same cycle: `Mem_Ready` wins and the stage completes normally.

## Test plan
- **Zero-wait instruction:** Reset, `Run`=1, `Mem_Ready`=1, `Mem_Access`=0 → `Stage` sequence 0,1,2,3,4,5,1; `Instruction_Count`=1 after the WriteBack edge; `Stall_Count`=0.
- **Fetch wait states:** `Mem_Ready` low for 3 cycles in Fetch → Fetch lasts 4 cycles; `Stall_Count`=3; `Stage_Done` high only in the 4th cycle.
- **NOP retire:** `NOP_FLAG`=1 in Decode → next `Stage`=1, `Instruction_Count`+1, Execute never entered. With `IFNR_FLAG`=1 and `NOP_FLAG`=1 together → `Stage`=7.
- **Timeout:** `MEM_TIMEOUT`=15, `Mem_Access`=1, `Mem_Ready`=0 in Memory → `Mem_Request` high exactly 15 cycles, then `Stage`=7 and `Fault`=1. Fault holds for 100 cycles until `Reset`.
- **Run drop:** `Run` deasserted during Execute → instruction completes WriteBack, `Stage`=0, count incremented once.
- **Reset mid-request:** `Reset` asserted during a Fetch wait → `Mem_Request`=0 before the next clock edge; all outputs at reset values; resumes at Fetch one cycle after `Reset` falls with `Run`=1.
